// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   be_merge  : byte-granular merge of a new word over an old word
//   wrPort_t  : write-port bundle at the default datapath geometry
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // be_merge works on the widest supported word. Callers zero-extend
  // into it and truncate the result back to their own width, so a
  // register file may be at most MAX_DATA_W bits wide.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef struct packed {
    logic                      en;
    logic [ADDR_W_DEF-1:0]     addr;
    logic [DATA_W_DEF/8-1:0]   be;
    logic [DATA_W_DEF-1:0]     data;
  } wrPort_t;

  // Byte b of the result is newWord's byte where be[b]=1, else oldWord's.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] oldWord,
    input logic [MAX_DATA_W-1:0] newWord,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = oldWord;
    for (int b = 0; b < MAX_BE_W; b++) begin
      if (be[b]) res[b*8 +: 8] = newWord[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: array mux, zero-register gate and write-to-read bypass.
// Latency: combinational, zero cycles.
// Backpressure: none; a read is always serviced in the cycle it is presented.
//   rst                         : bypass is suppressed while high
//   rdAddr / rdData             : read address and returned word
//   regs                        : current register array contents
//   wr{0,1}{En,Addr,Be,Data}    : this cycle's write ports, for forwarding
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rdAddr,
  input  logic [DATA_W-1:0]   regs [2**ADDR_W],
  input  logic                wr0En,
  input  logic [ADDR_W-1:0]   wr0Addr,
  input  logic [DATA_W/8-1:0] wr0Be,
  input  logic [DATA_W-1:0]   wr0Data,
  input  logic                wr1En,
  input  logic [ADDR_W-1:0]   wr1Addr,
  input  logic [DATA_W/8-1:0] wr1Be,
  input  logic [DATA_W-1:0]   wr1Data,
  output logic [DATA_W-1:0]   rdData
);

  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = regs[rdAddr];
    // Port 0 is merged first and port 1 on top, which gives port 1
    // priority per byte and reproduces exactly what the array will hold
    // after the edge. During reset the array is already zero, so
    // skipping the merge yields zero on every port.
    if ((BYPASS != 0) && !rst) begin
      if (wr0En && (wr0Addr == rdAddr)) begin
        merged = DATA_W'(be_merge(MAX_DATA_W'(merged), MAX_DATA_W'(wr0Data),
                                  MAX_BE_W'(wr0Be)));
      end
      if (wr1En && (wr1Addr == rdAddr)) begin
        merged = DATA_W'(be_merge(MAX_DATA_W'(merged), MAX_DATA_W'(wr1Data),
                                  MAX_BE_W'(wr1Be)));
      end
    end
    // Applied last so a forwarded write to r0 can never leak through.
    if ((ZERO_REG != 0) && (rdAddr == '0)) merged = '0;
  end

  assign rdData = merged;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NUM_RD read ports, two write ports.
// Latency: reads combinational (bypass optional); writes commit on rising clk_i.
// Backpressure: none; every request is accepted every cycle.
//   clk_i, rst_i                       : clock, async active-high clear
//   rd_addr_i / rd_data_o              : packed per-port read address / data
//   wr{0,1}_{en,addr,be,data}_i        : write ports, port 1 wins per byte
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     wr0_en_i,
  input  logic [ADDR_W-1:0]        wr0_addr_i,
  input  logic [DATA_W/8-1:0]      wr0_be_i,
  input  logic [DATA_W-1:0]        wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [ADDR_W-1:0]        wr1_addr_i,
  input  logic [DATA_W/8-1:0]      wr1_be_i,
  input  logic [DATA_W-1:0]        wr1_data_i
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [DATA_W-1:0] nextRegs [NUM_REGS];
  logic              wr0Live;
  logic              wr1Live;

  // With a hardwired zero register, writes to r0 are dropped here so the
  // storage for r0 stays at its reset value of zero.
  assign wr0Live = wr0_en_i && !((ZERO_REG != 0) && (wr0_addr_i == '0));
  assign wr1Live = wr1_en_i && !((ZERO_REG != 0) && (wr1_addr_i == '0));

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      nextRegs[i] = regs[i];
      // Port 1 merges over port 0 so a same-address collision keeps
      // port 0 bytes that port 1 does not enable.
      if (wr0Live && (wr0_addr_i == ADDR_W'(i))) begin
        nextRegs[i] = DATA_W'(be_merge(MAX_DATA_W'(nextRegs[i]),
                                       MAX_DATA_W'(wr0_data_i),
                                       MAX_BE_W'(wr0_be_i)));
      end
      if (wr1Live && (wr1_addr_i == ADDR_W'(i))) begin
        nextRegs[i] = DATA_W'(be_merge(MAX_DATA_W'(nextRegs[i]),
                                       MAX_DATA_W'(wr1_data_i),
                                       MAX_BE_W'(wr1_be_i)));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= nextRegs[i];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) uRdPort (
      .rst     (rst_i),
      .rdAddr  (rd_addr_i[k*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .wr0En   (wr0_en_i),
      .wr0Addr (wr0_addr_i),
      .wr0Be   (wr0_be_i),
      .wr0Data (wr0_data_i),
      .wr1En   (wr1_en_i),
      .wr1Addr (wr1_addr_i),
      .wr1Be   (wr1_be_i),
      .wr1Data (wr1_data_i),
      .rdData  (rd_data_o[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp plus a reference-model random run.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// Instances: uA default, uB ZERO_REG=0/BYPASS=0, uC 4x64-bit reads, 16 regs.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   vecs = 0;
  int   errs = 0;

  // Default geometry instance
  logic [9:0]  aRdAddr;
  logic [63:0] aRdData;
  wrPort_t     aW0, aW1;

  // ZERO_REG=0, BYPASS=0 instance
  logic [9:0]  bRdAddr;
  logic [63:0] bRdData;
  wrPort_t     bW0, bW1;

  // NUM_RD=4, DATA_W=64, ADDR_W=4 instance
  logic [15:0]  cRdAddr;
  logic [255:0] cRdData;
  logic         cW0En, cW1En;
  logic [3:0]   cW0Addr, cW1Addr;
  logic [7:0]   cW0Be, cW1Be;
  logic [63:0]  cW0Data, cW1Data;

  logic [31:0] mdl [32];

  regfile_mp uA (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(aRdAddr), .rd_data_o(aRdData),
    .wr0_en_i(aW0.en), .wr0_addr_i(aW0.addr), .wr0_be_i(aW0.be), .wr0_data_i(aW0.data),
    .wr1_en_i(aW1.en), .wr1_addr_i(aW1.addr), .wr1_be_i(aW1.be), .wr1_data_i(aW1.data)
  );

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) uB (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(bRdAddr), .rd_data_o(bRdData),
    .wr0_en_i(bW0.en), .wr0_addr_i(bW0.addr), .wr0_be_i(bW0.be), .wr0_data_i(bW0.data),
    .wr1_en_i(bW1.en), .wr1_addr_i(bW1.addr), .wr1_be_i(bW1.be), .wr1_data_i(bW1.data)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) uC (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(cRdAddr), .rd_data_o(cRdData),
    .wr0_en_i(cW0En), .wr0_addr_i(cW0Addr), .wr0_be_i(cW0Be), .wr0_data_i(cW0Data),
    .wr1_en_i(cW1En), .wr1_addr_i(cW1Addr), .wr1_be_i(cW1Be), .wr1_data_i(cW1Data)
  );

  // Expected read of address a on uA this cycle: stored bytes, then
  // port 0 bytes, then port 1 bytes overwrite in that order.
  function automatic logic [31:0] modelRead(input logic [4:0] a);
    logic [31:0] v;
    v = mdl[a];
    for (int b = 0; b < 4; b++) begin
      if (aW0.en && aW0.addr == a && aW0.be[b]) v[b*8 +: 8] = aW0.data[b*8 +: 8];
      if (aW1.en && aW1.addr == a && aW1.be[b]) v[b*8 +: 8] = aW1.data[b*8 +: 8];
    end
    if (a == 5'd0) v = '0;
    return v;
  endfunction

  task automatic test_reset();
    aW0 = '0; aW1 = '0; bW0 = '0; bW1 = '0;
    cW0En = 0; cW0Addr = '0; cW0Be = '0; cW0Data = '0;
    cW1En = 0; cW1Addr = '0; cW1Be = '0; cW1Data = '0;
    aRdAddr = {5'd5, 5'd5}; bRdAddr = '0; cRdAddr = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    vecs++; if (aRdData[31:0] !== 32'h0) begin errs++; $display("FAIL reset_initial: got %h want %h", aRdData[31:0], 32'h0); end
    aW0 = '{en: 1'b1, addr: 5'd5, be: 4'hF, data: 32'h5A5A_5A5A};
    #1;
    vecs++; if (aRdData[31:0] !== 32'h0) begin errs++; $display("FAIL reset_bypass_suppressed: got %h want %h", aRdData[31:0], 32'h0); end
    @(negedge clk); #1;
    vecs++; if (aRdData[31:0] !== 32'h0) begin errs++; $display("FAIL reset_write_ignored: got %h want %h", aRdData[31:0], 32'h0); end
    // release reset mid-burst; the very next edge must write
    @(negedge clk);
    rst = 1'b0; aW0.data = 32'hCAFE_F00D;
    #1;
    vecs++; if (aRdData[31:0] !== 32'hCAFE_F00D) begin errs++; $display("FAIL release_bypass: got %h want %h", aRdData[31:0], 32'hCAFE_F00D); end
    @(negedge clk); aW0.en = 1'b0; #1;
    vecs++; if (aRdData[31:0] !== 32'hCAFE_F00D) begin errs++; $display("FAIL release_first_edge: got %h want %h", aRdData[31:0], 32'hCAFE_F00D); end
    @(negedge clk); aW0.en = 1'b1; aW0.data = 32'hDEAD_BEEF;
    @(negedge clk); aW0.en = 1'b0; #1;
    vecs++; if (aRdData[31:0] !== 32'hDEAD_BEEF) begin errs++; $display("FAIL pre_reset_r5: got %h want %h", aRdData[31:0], 32'hDEAD_BEEF); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (aRdData[31:0] !== 32'h0) begin errs++; $display("FAIL async_clear_r5: got %h want %h", aRdData[31:0], 32'h0); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      aRdAddr = {5'(i), 5'(i)};
      #1;
      vecs++; if (aRdData !== 64'h0) begin errs++; $display("FAIL clear_all r%0d: got %h want %h", i, aRdData, 64'h0); end
    end
    bRdAddr = '0; cRdAddr = 16'hFFFF;
    #1;
    vecs++; if (bRdData !== 64'h0) begin errs++; $display("FAIL clear_b: got %h want %h", bRdData, 64'h0); end
    vecs++; if (cRdData !== 256'h0) begin errs++; $display("FAIL clear_c: got %h want 0", cRdData); end
  endtask

  task automatic test_byte_en();
    @(negedge clk);
    aW0 = '{en: 1'b1, addr: 5'd3, be: 4'hF, data: 32'h1122_3344};
    aRdAddr = {5'd3, 5'd3};
    @(negedge clk);
    aW0 = '{en: 1'b1, addr: 5'd3, be: 4'b0101, data: 32'hAABB_CCDD};
    #1;
    vecs++; if (aRdData[63:32] !== 32'h11BB_33DD) begin errs++; $display("FAIL byte_en_bypass: got %h want %h", aRdData[63:32], 32'h11BB_33DD); end
    @(negedge clk);
    aW0 = '{en: 1'b1, addr: 5'd3, be: 4'h0, data: 32'hFFFF_FFFF};
    #1;
    vecs++; if (aRdData[31:0] !== 32'h11BB_33DD) begin errs++; $display("FAIL byte_en_zero_mask_bypass: got %h want %h", aRdData[31:0], 32'h11BB_33DD); end
    @(negedge clk); aW0.en = 1'b0; #1;
    vecs++; if (aRdData !== {2{32'h11BB_33DD}}) begin errs++; $display("FAIL byte_en_stored: got %h want %h", aRdData, {2{32'h11BB_33DD}}); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    aW0 = '{en: 1'b1, addr: 5'd7, be: 4'hF,    data: 32'h0000_FFFF};
    aW1 = '{en: 1'b1, addr: 5'd7, be: 4'b1100, data: 32'h1234_5678};
    aRdAddr = {5'd7, 5'd7};
    #1;
    vecs++; if (aRdData !== {2{32'h1234_FFFF}}) begin errs++; $display("FAIL collision_bypass: got %h want %h", aRdData, {2{32'h1234_FFFF}}); end
    @(negedge clk);
    aW0 = '{en: 1'b1, addr: 5'd10, be: 4'hF, data: 32'h1010_1010};
    aW1 = '{en: 1'b1, addr: 5'd11, be: 4'hF, data: 32'h2020_2020};
    aRdAddr = {5'd11, 5'd7};
    #1;
    vecs++; if (aRdData[31:0] !== 32'h1234_FFFF) begin errs++; $display("FAIL collision_stored: got %h want %h", aRdData[31:0], 32'h1234_FFFF); end
    vecs++; if (aRdData[63:32] !== 32'h2020_2020) begin errs++; $display("FAIL diff_addr_bypass: got %h want %h", aRdData[63:32], 32'h2020_2020); end
    @(negedge clk);
    aW0 = '{en: 1'b1, addr: 5'd7, be: 4'b1111, data: 32'hAAAA_AAAA};
    aW1 = '{en: 1'b1, addr: 5'd7, be: 4'b0011, data: 32'h5555_5555};
    aRdAddr = {5'd11, 5'd10};
    #1;
    vecs++; if (aRdData !== {32'h2020_2020, 32'h1010_1010}) begin errs++; $display("FAIL diff_addr_stored: got %h want %h", aRdData, {32'h2020_2020, 32'h1010_1010}); end
    @(negedge clk); aW0.en = 1'b0; aW1.en = 1'b0; aRdAddr = {5'd7, 5'd7}; #1;
    vecs++; if (aRdData !== {2{32'hAAAA_5555}}) begin errs++; $display("FAIL collision_merge: got %h want %h", aRdData, {2{32'hAAAA_5555}}); end
  endtask

  task automatic test_zero();
    @(negedge clk);
    aW0 = '{en: 1'b1, addr: 5'd0, be: 4'hF, data: 32'hFFFF_FFFF};
    aW1 = aW0;
    aRdAddr = '0;
    #1;
    vecs++; if (aRdData !== 64'h0) begin errs++; $display("FAIL zero_write_cycle: got %h want %h", aRdData, 64'h0); end
    @(negedge clk); aW0.en = 1'b0; aW1.en = 1'b0; #1;
    vecs++; if (aRdData !== 64'h0) begin errs++; $display("FAIL zero_after: got %h want %h", aRdData, 64'h0); end
    @(negedge clk);
    bW0 = '{en: 1'b1, addr: 5'd0, be: 4'hF, data: 32'hFFFF_FFFF};
    bRdAddr = '0;
    #1;
    vecs++; if (bRdData[31:0] !== 32'h0) begin errs++; $display("FAIL nozero_write_cycle: got %h want %h", bRdData[31:0], 32'h0); end
    @(negedge clk); bW0.en = 1'b0; #1;
    vecs++; if (bRdData[31:0] !== 32'hFFFF_FFFF) begin errs++; $display("FAIL nozero_after: got %h want %h", bRdData[31:0], 32'hFFFF_FFFF); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bW0 = '{en: 1'b1, addr: 5'd9, be: 4'hF, data: 32'h5A5A_5A5A};
    bRdAddr = {5'd9, 5'd9};
    #1;
    vecs++; if (bRdData !== 64'h0) begin errs++; $display("FAIL nobypass_write_cycle: got %h want %h", bRdData, 64'h0); end
    @(negedge clk); bW0.en = 1'b0; #1;
    vecs++; if (bRdData !== {2{32'h5A5A_5A5A}}) begin errs++; $display("FAIL nobypass_next: got %h want %h", bRdData, {2{32'h5A5A_5A5A}}); end
    @(negedge clk);
    aW0 = '{en: 1'b1, addr: 5'd9, be: 4'hF, data: 32'h5A5A_5A5A};
    aRdAddr = {5'd9, 5'd9};
    #1;
    vecs++; if (aRdData !== {2{32'h5A5A_5A5A}}) begin errs++; $display("FAIL bypass_write_cycle: got %h want %h", aRdData, {2{32'h5A5A_5A5A}}); end
    @(negedge clk); aW0.en = 1'b0;
  endtask

  task automatic test_port_scaling();
    @(negedge clk);
    cW0En = 1'b1; cW0Addr = 4'hF; cW0Be = 8'hFF; cW0Data = 64'h0123_4567_89AB_CDEF;
    cRdAddr = 16'hFFFF;
    #1;
    for (int k = 0; k < 4; k++) begin
      vecs++; if (cRdData[k*64 +: 64] !== 64'h0123_4567_89AB_CDEF) begin errs++; $display("FAIL wide_bypass p%0d: got %h want %h", k, cRdData[k*64 +: 64], 64'h0123_4567_89AB_CDEF); end
    end
    @(negedge clk); cW0En = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      vecs++; if (cRdData[k*64 +: 64] !== 64'h0123_4567_89AB_CDEF) begin errs++; $display("FAIL wide_stored p%0d: got %h want %h", k, cRdData[k*64 +: 64], 64'h0123_4567_89AB_CDEF); end
    end
    @(negedge clk);
    cW1En = 1'b1; cW1Addr = 4'hF; cW1Be = 8'h0F; cW1Data = 64'hFFFF_FFFF_FFFF_FFFF;
    cRdAddr = 16'hEFFF;
    @(negedge clk); cW1En = 1'b0; #1;
    vecs++; if (cRdData !== {64'h0, {3{64'h0123_4567_FFFF_FFFF}}}) begin errs++; $display("FAIL wide_partial: got %h want %h", cRdData, {64'h0, {3{64'h0123_4567_FFFF_FFFF}}}); end
  endtask

  task automatic test_random();
    logic [31:0] n0, n1, got, exp;
    logic [4:0]  ra;
    @(negedge clk);
    aW0.en = 1'b0; aW1.en = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      aW0 = '{en: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 7)), be: 4'($urandom), data: $urandom};
      aW1 = '{en: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 7)), be: 4'($urandom), data: $urandom};
      aRdAddr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 7))};
      #1;
      for (int k = 0; k < 2; k++) begin
        ra  = aRdAddr[k*5 +: 5];
        exp = modelRead(ra);
        got = aRdData[k*32 +: 32];
        vecs++; if (got !== exp) begin errs++; $display("FAIL random n%0d p%0d r%0d: got %h want %h", n, k, ra, got, exp); end
      end
      n0 = modelRead(aW0.addr);
      n1 = modelRead(aW1.addr);
      if (aW0.en) mdl[aW0.addr] = n0;
      if (aW1.en) mdl[aW1.addr] = n1;
    end
    @(negedge clk); aW0.en = 1'b0; aW1.en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_en();
    test_collision();
    test_zero();
    test_bypass();
    test_port_scaling();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the CPU datapath; successor to the single-write, two-read, fixed-32x32 register file.
- Adds configurable width, depth and read-port count, a second write port with fixed priority, per-byte write enables, asynchronous clear, an optional hardwired zero register, and optional write-to-read bypass.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth NUM_REGS = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1, a same-cycle write to a read address is forwarded to that read port.

Ports:
- clk_i, in, 1, clock; all state updates on the rising edge.
- rst_i, in, 1, asynchronous active-high reset.
- rd_addr_i, in, NUM_RD*ADDR_W, read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data_o, out, NUM_RD*DATA_W, read data; port k occupies bits [k*DATA_W +: DATA_W].
- wr0_en_i, in, 1, write port 0 enable.
- wr0_addr_i, in, ADDR_W, write port 0 address.
- wr0_be_i, in, DATA_W/8, write port 0 byte enables.
- wr0_data_i, in, DATA_W, write port 0 data.
- wr1_en_i, wr1_addr_i, wr1_be_i, wr1_data_i: same as port 0, for write port 1.

Behaviour:
- Reset: while rst_i=1, all NUM_REGS registers clear to 0 immediately, with no clock required.
  - Writes are ignored while rst_i=1.
  - Bypass is suppressed while rst_i=1, so every rd_data_o reads 0.
  - Deassertion of rst_i mid-burst: the first edge with rst_i=0 performs writes normally.
- Write:
  - On posedge clk_i with rst_i=0 and wrN_en_i=1, byte b of register[wrN_addr_i] takes wrN_data_i byte b wherever wrN_be_i[b]=1; other bytes hold.
  - wrN_en_i=1 with wrN_be_i all zero writes nothing.
- Simultaneous writes:
  - Different addresses: both commit.
  - Same address: per byte, port 1 wins where wr1_be_i[b]=1; port 0 bytes not enabled on port 1 still commit (byte-merged).
- Zero register: with ZERO_REG=1, writes to address 0 are dropped on both ports, and reads of address 0 return 0 including through the bypass path. With ZERO_REG=0, register 0 is ordinary storage.
- Read: combinational, zero latency. rd_data_o[k] = register[rd_addr_i[k]].
- Bypass (BYPASS=1, rst_i=0): if rd_addr_i[k] matches an enabled write address this cycle, each byte of rd_data_o[k] is formed in priority order:
  - wr1 data where wr1 matches and wr1_be_i[b]=1;
  - else wr0 data where wr0 matches and wr0_be_i[b]=1;
  - else the stored byte.
  - Forwarded value equals the value the register holds after the edge.
- No bypass (BYPASS=0): reads return pre-edge contents; the new value is visible from the cycle after the write.
- Any number of read ports may address the same register, and each returns an identical value.
- No X on outputs after reset for any address.

Decomposition:
- Package regfile_pkg:
  - constants DATA_W_DEF=32 and ADDR_W_DEF=5;
  - function be_merge(old, new, be) returning the byte-merged word;
  - typedef for a write-port bundle (en, addr, be, data).
- One sub-module, regfile_rd_port: a single read port comprising the array mux, the zero-register gate and the bypass/byte-merge logic. It is instantiated NUM_RD times via generate.
- Storage and write logic stay in regfile_mp.

Test Plan:
1. Reset clear: write 0xDEADBEEF to r5, then assert rst_i between clock edges -> rd_data_o for r5 reads 0 immediately; after release, all 32 registers read 0.
2. Byte enables: write r3=0x11223344 with be=4'hF, then write 0xAABBCCDD with be=4'b0101 -> r3 reads 0x11BB33DD.
3. Dual-write collision: in one cycle, wr0 writes r7=0x0000FFFF with be=4'hF and wr1 writes r7=0x12345678 with be=4'b1100 -> r7=0x1234FFFF, and the bypassed read of r7 in that same cycle also shows 0x1234FFFF.
4. Zero register: wr0 and wr1 both write r0=0xFFFFFFFF -> r0 reads 0 during the write cycle and afterwards. Repeat with ZERO_REG=0 -> r0 reads 0xFFFFFFFF after the edge.
5. Bypass off vs on: with BYPASS=0, write r9=0x5A5A5A5A while reading r9 (old value 0) -> 0 in the write cycle, 0x5A5A5A5A in the next. With BYPASS=1 -> 0x5A5A5A5A in the write cycle.
6. Port scaling: NUM_RD=4, DATA_W=64, ADDR_W=4, all four ports reading r15 after a write of 0x0123456789ABCDEF -> all four outputs are equal. Randomized comparison against a reference model over 10k cycles -> zero mismatches.
